// File: rtl/ft_bus_arbiter_pkg.sv
// Shared types and constants for the FTDI FIFO bus arbiter.
package ft_pkg;

  localparam int unsigned BurstW = 16;
  localparam int unsigned TimerW = 16;
  localparam int unsigned TurnW  = 4;
  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    StIdle     = 3'd0,
    StRdOe     = 3'd1,
    StRdActive = 3'd2,
    StWrActive = 3'd3,
    StTurn     = 3'd4,
    StSuspend  = 3'd5
  } bus_state_e;

  typedef enum logic {
    LsRead  = 1'b0,
    LsWrite = 1'b1
  } last_served_e;

  // States in which a SIWU pulse must not appear on the bus.
  function automatic logic is_defer_state(bus_state_e s);
    return s inside {StRdOe, StRdActive, StSuspend};
  endfunction

endpackage

// File: rtl/ft_bus_arbiter_if.sv
// Handshake bundle between the bus arbiter (master) and the read/write engines (slave).
interface ft_bus_arbiter_if;
  import ft_pkg::*;

  logic              ftdi_suspend_n;
  logic              rd_req;
  logic              rd_beat;
  logic              wr_req;
  logic              wr_beat;
  logic              flush_req;
  logic              rd_grant;
  logic              wr_grant;
  logic              ftdi_oe_n;
  logic              drive_en;
  logic              ftdi_siwu;
  logic [StateW-1:0] bus_state;

  modport master (
    input  ftdi_suspend_n, rd_req, rd_beat, wr_req, wr_beat, flush_req,
    output rd_grant, wr_grant, ftdi_oe_n, drive_en, ftdi_siwu, bus_state
  );

  modport slave (
    output ftdi_suspend_n, rd_req, rd_beat, wr_req, wr_beat, flush_req,
    input  rd_grant, wr_grant, ftdi_oe_n, drive_en, ftdi_siwu, bus_state
  );

endinterface

// File: rtl/ft_bus_arbiter_siwu_flush.sv
// SIWU send-immediately generator: pending flag, idle timer, deferral and one-cycle pulse.
module ft_siwu_flush
  import ft_pkg::*;
#(
  parameter int unsigned FLUSH_TIMEOUT = 64
) (
  input  logic ftdi_clk,
  input  logic rst,
  input  logic wr_beat_i,
  input  logic flush_req_i,
  input  logic defer_i,
  output logic siwu_o
);

  localparam logic [TimerW-1:0] TimerMax = TimerW'(FLUSH_TIMEOUT);
  localparam logic [TimerW-1:0] FireAt   = TimerW'(FLUSH_TIMEOUT - 1);

  logic              pending_q;
  logic              deferred_q;
  logic              siwu_q;
  logic [TimerW-1:0] timer_q;
  logic              fire_req;
  logic              fire;

  // A deferred request keeps firing until it lands outside a defer state.
  assign fire_req = pending_q && (timer_q == FireAt || flush_req_i || deferred_q);
  assign fire     = fire_req && !defer_i;

  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      pending_q  <= 1'b0;
      deferred_q <= 1'b0;
      siwu_q     <= 1'b1;
      timer_q    <= '0;
    end else begin
      siwu_q     <= !fire;
      deferred_q <= fire_req && defer_i;
      if (wr_beat_i) begin
        pending_q <= 1'b1;
        timer_q   <= '0;
      end else if (fire) begin
        pending_q <= 1'b0;
        timer_q   <= '0;
      end else if (pending_q && timer_q != TimerMax) begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

  assign siwu_o = siwu_q;

endmodule

// File: rtl/ft_bus_arbiter.sv
// Grants the shared FT245 synchronous FIFO bus to the read or write engine with
// turnaround gaps, burst fairness, suspend handling and SIWU flush.
module ft_bus_arbiter
  import ft_pkg::*;
#(
  parameter int unsigned MAX_RD_BURST  = 512,
  parameter int unsigned MAX_WR_BURST  = 512,
  parameter int unsigned TURNAROUND    = 1,
  parameter int unsigned FLUSH_TIMEOUT = 64
) (
  input  logic             ftdi_clk,
  input  logic             rst,
  ft_bus_arbiter_if.master bus_io
);

  localparam logic [BurstW-1:0] RdLimit  = BurstW'(MAX_RD_BURST - 1);
  localparam logic [BurstW-1:0] WrLimit  = BurstW'(MAX_WR_BURST - 1);
  localparam logic [TurnW-1:0]  TurnLoad = TurnW'(TURNAROUND - 1);

  bus_state_e        state_q, state_d;
  last_served_e      last_served_q;
  logic [BurstW-1:0] burst_cnt_q;
  logic [TurnW-1:0]  turn_cnt_q;
  logic              rd_grant_q, wr_grant_q, oe_n_q, drive_en_q;

  logic              beat;
  logic              at_limit;
  logic [BurstW-1:0] burst_limit;
  logic              is_active;

  assign is_active   = state_q inside {StRdActive, StWrActive};
  assign beat        = (state_q == StRdActive) ? bus_io.rd_beat :
                       (state_q == StWrActive) ? bus_io.wr_beat : 1'b0;
  assign burst_limit = (state_q == StWrActive) ? WrLimit : RdLimit;
  assign at_limit    = beat && (burst_cnt_q == burst_limit);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!bus_io.ftdi_suspend_n) begin
          state_d = StSuspend;
        end else if (bus_io.rd_req && (!bus_io.wr_req || last_served_q == LsWrite)) begin
          state_d = StRdOe;
        end else if (bus_io.wr_req) begin
          state_d = StWrActive;
        end
      end
      StRdOe: state_d = StRdActive;
      StRdActive: begin
        if (!bus_io.rd_req || !bus_io.ftdi_suspend_n || (at_limit && bus_io.wr_req)) begin
          state_d = StTurn;
        end
      end
      StWrActive: begin
        if (!bus_io.wr_req || !bus_io.ftdi_suspend_n || (at_limit && bus_io.rd_req)) begin
          state_d = StTurn;
        end
      end
      StTurn:    if (turn_cnt_q == '0) state_d = StIdle;
      StSuspend: if (bus_io.ftdi_suspend_n) state_d = StTurn;
      default:   state_d = StIdle;
    endcase
  end

  // Bus outputs are decoded from the next state so they change on the state-entry edge.
  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      state_q       <= StIdle;
      last_served_q <= LsWrite;
      burst_cnt_q   <= '0;
      turn_cnt_q    <= '0;
      rd_grant_q    <= 1'b0;
      wr_grant_q    <= 1'b0;
      oe_n_q        <= 1'b1;
      drive_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_grant_q <= (state_d == StRdActive);
      wr_grant_q <= (state_d == StWrActive);
      oe_n_q     <= !(state_d inside {StRdOe, StRdActive});
      drive_en_q <= (state_d == StWrActive);

      if (state_d == StTurn && state_q != StTurn) begin
        turn_cnt_q <= TurnLoad;
      end else if (state_q == StTurn && turn_cnt_q != '0) begin
        turn_cnt_q <= turn_cnt_q - 1'b1;
      end

      if (is_active && state_d == StTurn) begin
        burst_cnt_q   <= '0;
        last_served_q <= (state_q == StRdActive) ? LsRead : LsWrite;
      end else if (beat && burst_cnt_q != burst_limit) begin
        burst_cnt_q <= burst_cnt_q + 1'b1;
      end
    end
  end

  ft_siwu_flush #(
    .FLUSH_TIMEOUT (FLUSH_TIMEOUT)
  ) u_siwu_flush (
    .ftdi_clk    (ftdi_clk),
    .rst         (rst),
    .wr_beat_i   (bus_io.wr_beat && wr_grant_q),
    .flush_req_i (bus_io.flush_req),
    .defer_i     (is_defer_state(state_d)),
    .siwu_o      (bus_io.ftdi_siwu)
  );

  assign bus_io.rd_grant  = rd_grant_q;
  assign bus_io.wr_grant  = wr_grant_q;
  assign bus_io.ftdi_oe_n = oe_n_q;
  assign bus_io.drive_en  = drive_en_q;
  assign bus_io.bus_state = state_q;

endmodule

// File: tb/tb_ft_bus_arbiter.sv
// Directed self-checking bench for ft_bus_arbiter with a queue-based expectation scoreboard.
module tb_ft_bus_arbiter;

  localparam logic [2:0] SIdle = 3'd0, SRdOe = 3'd1, SRdAct = 3'd2, SWrAct = 3'd3,
                         STurn = 3'd4, SSusp = 3'd5;

  logic ftdi_clk;
  logic rst;
  int   checks;
  int   errors;

  logic [31:0] exp_val_q[$];
  string       exp_tag_q[$];

  ft_bus_arbiter_if bus ();

  ft_bus_arbiter #(
    .MAX_RD_BURST  (4),
    .MAX_WR_BURST  (8),
    .TURNAROUND    (1),
    .FLUSH_TIMEOUT (64)
  ) dut (
    .ftdi_clk (ftdi_clk),
    .rst      (rst),
    .bus_io   (bus)
  );

  initial ftdi_clk = 1'b0;
  always #5 ftdi_clk = ~ftdi_clk;

  task automatic tick();
    @(posedge ftdi_clk);
    #1;
  endtask

  task automatic want(string tag, logic [31:0] v);
    exp_tag_q.push_back(tag);
    exp_val_q.push_back(v);
  endtask

  task automatic got(logic [31:0] obs);
    string       tag;
    logic [31:0] v;
    checks++;
    if (exp_val_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_underflow: got %0h with no expected entry queued", obs);
      return;
    end
    tag = exp_tag_q.pop_front();
    v   = exp_val_q.pop_front();
    assert (obs === v) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, v);
    end
  endtask

  task automatic check_bus(string tag, logic [2:0] st, logic rg, logic wg, logic oe_n,
                           logic de, logic siwu);
    want({tag, ".state"}, 32'(st));
    want({tag, ".rd_grant"}, 32'(rg));
    want({tag, ".wr_grant"}, 32'(wg));
    want({tag, ".oe_n"}, 32'(oe_n));
    want({tag, ".drive_en"}, 32'(de));
    want({tag, ".siwu"}, 32'(siwu));
    got(32'(bus.bus_state));
    got(32'(bus.rd_grant));
    got(32'(bus.wr_grant));
    got(32'(bus.ftdi_oe_n));
    got(32'(bus.drive_en));
    got(32'(bus.ftdi_siwu));
  endtask

  task automatic do_reset();
    rst                = 1'b1;
    bus.ftdi_suspend_n = 1'b1;
    bus.rd_req         = 1'b0;
    bus.rd_beat        = 1'b0;
    bus.wr_req         = 1'b0;
    bus.wr_beat        = 1'b0;
    bus.flush_req      = 1'b0;
    tick();
    tick();
  endtask

  // Read OE and FPGA data drive must never be active together.
  always @(negedge ftdi_clk) begin
    checks++;
    assert (!(bus.ftdi_oe_n === 1'b0 && bus.drive_en === 1'b1)) else begin
      errors++;
      $error("FAIL oe_drive_overlap: got oe_n=%b drive_en=%b expected not both active",
             bus.ftdi_oe_n, bus.drive_en);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int lows;
    logic [2:0] seq2 [8];
    logic [2:0] seq6 [6];
    checks = 0;
    errors = 0;

    // Reset state, and flush_req with nothing pending
    do_reset();
    check_bus("reset", SIdle, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    lows = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.ftdi_siwu === 1'b0) lows++;
      tick();
    end
    want("idle_flush_no_pulse", 0);
    got(lows);

    // Test 1: single read
    bus.rd_req = 1'b1;
    tick();
    check_bus("t1.c1", SRdOe, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_bus("t1.c2", SRdAct, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    bus.rd_req = 1'b0;
    tick();
    check_bus("t1.turn", STurn, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    check_bus("t1.idle", SIdle, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Test 2: both request, read first, preempted after 4 beats
    do_reset();
    rst = 1'b0;
    bus.rd_req  = 1'b1;
    bus.wr_req  = 1'b1;
    bus.rd_beat = 1'b1;
    seq2 = '{SRdOe, SRdAct, SRdAct, SRdAct, SRdAct, STurn, SIdle, SWrAct};
    foreach (seq2[i]) want($sformatf("t2.state%0d", i), 32'(seq2[i]));
    foreach (seq2[i]) begin
      tick();
      got(32'(bus.bus_state));
    end
    check_bus("t2.wr", SWrAct, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    bus.rd_req  = 1'b0;
    bus.rd_beat = 1'b0;
    bus.wr_req  = 1'b0;
    tick();
    check_bus("t2.turn", STurn, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Test 3: 10-beat write then auto SIWU 64 cycles after the last beat
    do_reset();
    rst = 1'b0;
    bus.wr_req = 1'b1;
    tick();
    bus.wr_beat = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    want("t3.saturated_grant", 32'(SWrAct));
    got(32'(bus.bus_state));
    bus.wr_beat = 1'b0;
    bus.wr_req  = 1'b0;
    k = 0;
    for (int i = 1; i <= 200 && k == 0; i++) begin
      tick();
      if (bus.ftdi_siwu === 1'b0) k = i;
    end
    want("t3.siwu_delay", 64);
    got(k);
    tick();
    want("t3.siwu_width", 1);
    got(32'(bus.ftdi_siwu));
    lows = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (bus.ftdi_siwu === 1'b0) lows++;
    end
    want("t3.no_second_pulse", 0);
    got(lows);

    // Test 4: flush_req during a read is deferred to the first TURN cycle
    do_reset();
    rst = 1'b0;
    bus.wr_req = 1'b1;
    tick();
    bus.wr_beat = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.wr_beat = 1'b0;
    bus.wr_req  = 1'b0;
    bus.rd_req  = 1'b1;
    lows = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.ftdi_siwu === 1'b0) lows++;
    end
    want("t4.in_read", 32'(SRdAct));
    got(32'(bus.bus_state));
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.ftdi_siwu === 1'b0) lows++;
      tick();
    end
    want("t4.no_siwu_in_read", 0);
    got(lows);
    bus.rd_req = 1'b0;
    tick();
    check_bus("t4.turn_pulse", STurn, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.ftdi_siwu === 1'b0) lows++;
    end
    want("t4.single_pulse", 0);
    got(lows);

    // Test 5: suspend mid-write
    do_reset();
    rst = 1'b0;
    bus.wr_req = 1'b1;
    tick();
    bus.wr_beat = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus.ftdi_suspend_n = 1'b0;
    tick();
    bus.wr_beat = 1'b0;
    check_bus("t5.drop", STurn, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    want("t5.idle", 32'(SIdle));
    got(32'(bus.bus_state));
    tick();
    tick();
    check_bus("t5.suspend", SSusp, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    bus.ftdi_suspend_n = 1'b1;
    tick();
    want("t5.release_turn", 32'(STurn));
    got(32'(bus.bus_state));
    tick();
    want("t5.release_idle", 32'(SIdle));
    got(32'(bus.bus_state));
    tick();
    check_bus("t5.regrant", SWrAct, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

    // Test 6: reset during a read burst, counters cleared
    do_reset();
    rst = 1'b0;
    bus.rd_req = 1'b1;
    tick();
    tick();
    bus.rd_beat = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_bus("t6.reset", SIdle, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    bus.wr_req = 1'b1;
    seq6 = '{SRdOe, SRdAct, SRdAct, SRdAct, SRdAct, STurn};
    foreach (seq6[i]) want($sformatf("t6.state%0d", i), 32'(seq6[i]));
    foreach (seq6[i]) begin
      tick();
      got(32'(bus.bus_state));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
